// File: rtl/gpio_intr_ctrl.sv
// gpio_intr_ctrl: round-robin GPIO interrupt claim, core handshake, APB clear write.
//   clk, rst            : clock, synchronous active-high reset
//   intr_stat, irq_mask : per-pin sticky status and arbitration mask
//   irq_valid, irq_id   : claimed pin presented to the core
//   irq_ack             : core done with irq_id (honoured only while presenting)
//   bus_req, bus_gnt    : shared APB request / grant
//   PSEL..PWDATA        : APB master write of the interrupt-clear register
module gpio_intr_ctrl #(
    parameter int          NUM_PINS   = 8,
    parameter logic [31:0] GPIO_BASE  = 32'h0,
    parameter logic [31:0] CLR_OFFSET = 32'h18,
    parameter int          CLR_WAIT   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] intr_stat,
    input  logic [NUM_PINS-1:0] irq_mask,
    output logic                irq_valid,
    output logic [4:0]          irq_id,
    input  logic                irq_ack,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [31:0]         PADDR,
    output logic [31:0]         PWDATA
);
    localparam int LW = NUM_PINS > 1 ? $clog2(NUM_PINS) : 1;
    localparam int CW = $clog2(CLR_WAIT + 1);

    typedef enum logic [2:0] {IDLE, PRESENT, REQ, SETUP, ACCESS, WAIT_CLR} state_t;

    state_t                state;
    logic [LW-1:0]         last;
    logic [LW-1:0]         win;
    logic [CW-1:0]         cnt;
    logic [NUM_PINS-1:0]   pending;
    logic [NUM_PINS-1:0]   rot;
    int                    off;
    int                    pos;

    assign pending = intr_stat & ~irq_mask;
    // rot[k] is pending pin (last+1+k) mod NUM_PINS; the LW-bit wrap of last+1
    // is harmless because it only happens when NUM_PINS is a power of two.
    assign rot = NUM_PINS'({pending, pending} >> (last + 1'b1));

    always_comb begin
        off = 0;
        for (int k = NUM_PINS - 1; k >= 0; k--)
            if (rot[k]) off = k;
        pos = int'(last) + 1 + off;
        win = LW'(pos >= NUM_PINS ? pos - NUM_PINS : pos);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LW'(NUM_PINS - 1);
            cnt       <= '0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            bus_req   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            case (state)
                IDLE: if (|pending) begin
                    state     <= PRESENT;
                    irq_valid <= 1'b1;
                    irq_id    <= 5'(win);
                end
                PRESENT: if (irq_ack) begin
                    state     <= REQ;
                    irq_valid <= 1'b0;
                    bus_req   <= 1'b1;
                end
                REQ: if (bus_gnt) begin
                    state  <= SETUP;
                    PSEL   <= 1'b1;
                    PWRITE <= 1'b1;
                    PADDR  <= GPIO_BASE + CLR_OFFSET;
                    PWDATA <= 32'd1 << irq_id;
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    state   <= WAIT_CLR;
                    cnt     <= '0;
                    bus_req <= 1'b0;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    PADDR   <= '0;
                    PWDATA  <= '0;
                end
                // a re-fired pin keeps its bit set, so leave by timeout instead
                WAIT_CLR: if (!intr_stat[irq_id[LW-1:0]] || cnt == CW'(CLR_WAIT - 1)) begin
                    state  <= IDLE;
                    last   <= irq_id[LW-1:0];
                    irq_id <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// tb_gpio_intr_ctrl: timeline model of the interrupt transaction plus directed scenarios.
module tb_gpio_intr_ctrl;
    localparam int          N        = 8;
    localparam int          CW       = 4;
    localparam logic [31:0] BASE     = 32'h4001_0000;
    localparam logic [31:0] CLR_ADDR = 32'h4001_0018;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] intr_stat = '0;
    logic [N-1:0] irq_mask = '0;
    logic         irq_ack = 1'b0;
    logic         bus_gnt = 1'b1;
    logic         irq_valid, bus_req, PSEL, PENABLE, PWRITE;
    logic [4:0]   irq_id;
    logic [31:0]  PADDR, PWDATA;

    gpio_intr_ctrl #(.NUM_PINS(N), .GPIO_BASE(BASE), .CLR_OFFSET(32'h18), .CLR_WAIT(CW)) dut (
        .clk(clk), .rst(rst), .intr_stat(intr_stat), .irq_mask(irq_mask),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction timeline: claim time, cycle the ack was taken, cycle the grant was taken.
    int  cyc = 0;
    int  t_ack = -1;
    int  t_gnt = -1;
    int  m_last = N - 1;
    int  m_id = 0;
    bit  m_claim = 1'b0;

    function automatic int rr(input logic [N-1:0] p, input int from);
        for (int d = 1; d <= N; d++) begin
            int k = (from + d) % N;
            if (((p >> k) & 1) != 0) return k;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [N-1:0] pend = intr_stat & ~irq_mask;
        if (rst) begin
            m_claim = 1'b0;
            t_ack = -1;
            t_gnt = -1;
            m_last = N - 1;
        end else if (!m_claim) begin
            if (pend != 0) begin
                m_id = rr(pend, m_last);
                m_claim = 1'b1;
                t_ack = -1;
                t_gnt = -1;
            end
        end else if (t_ack < 0) begin
            if (irq_ack) t_ack = cyc;
        end else if (t_gnt < 0) begin
            if (bus_gnt) t_gnt = cyc;
        end else if (cyc >= t_gnt + 3) begin
            if (((intr_stat >> m_id) & 1) == 0 || cyc - (t_gnt + 3) == CW - 1) begin
                m_claim = 1'b0;
                m_last = m_id;
            end
        end
        cyc++;
    endtask

    task automatic model_compare();
        bit v  = m_claim && t_ack < 0;
        bit br = m_claim && t_ack >= 0 && (t_gnt < 0 || cyc <= t_gnt + 2);
        bit ps = m_claim && t_gnt >= 0 && (cyc == t_gnt + 1 || cyc == t_gnt + 2);
        bit pe = m_claim && t_gnt >= 0 && cyc == t_gnt + 2;
        chk("m_irq_valid", 32'(irq_valid), 32'(v));
        chk("m_bus_req", 32'(bus_req), 32'(br));
        chk("m_psel", 32'(PSEL), 32'(ps));
        chk("m_penable", 32'(PENABLE), 32'(pe));
        chk("m_pwrite", 32'(PWRITE), 32'(ps));
        chk("m_paddr", PADDR, ps ? CLR_ADDR : 32'h0);
        chk("m_pwdata", PWDATA, ps ? 32'd1 << m_id : 32'h0);
        if (v) chk("m_irq_id", 32'(irq_id), 32'(m_id));
        else if (!m_claim) chk("m_irq_id_idle", 32'(irq_id), 32'h0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1 model_compare();
    end

    // GPIO side: a clear write drops the status two cycles after ACCESS,
    // except stuck bits; refire bits come back one cycle after their clear.
    logic [N-1:0] stuck = '0;
    logic [N-1:0] refire = '0;
    logic [N-1:0] refire_now = '0;
    logic [N-1:0] clr_bits = '0;
    int           clr_cnt = 0;

    task automatic tick();
        @(negedge clk);
        if (refire_now != 0) begin
            intr_stat = intr_stat | refire_now;
            refire_now = '0;
        end
        if (clr_cnt > 0) begin
            clr_cnt--;
            if (clr_cnt == 0) begin
                intr_stat = intr_stat & ~(clr_bits & ~stuck);
                refire_now = clr_bits & refire;
                refire = refire & ~clr_bits;
            end
        end
        if (PSEL && PENABLE && PWRITE && PADDR == CLR_ADDR) begin
            clr_bits = PWDATA[N-1:0];
            clr_cnt = 2;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!irq_valid && n < 60) begin
            tick();
            n++;
        end
        if (!irq_valid) begin
            errors++;
            $display("FAIL wait_valid timeout at %0t", $time);
        end
    endtask

    task automatic wait_penable();
        int n = 0;
        while (!PENABLE && n < 30) begin
            tick();
            n++;
        end
        if (!PENABLE) begin
            errors++;
            $display("FAIL wait_penable timeout at %0t", $time);
        end
    endtask

    task automatic ack_now();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic serve(input string name, input int exp_id);
        wait_valid();
        chk(name, 32'(irq_id), 32'(exp_id));
        ack_now();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"}, 32'(irq_valid), 32'h0);
        chk({name, "_id"}, 32'(irq_id), 32'h0);
        chk({name, "_req"}, 32'(bus_req), 32'h0);
        chk({name, "_psel"}, 32'(PSEL), 32'h0);
        chk({name, "_pen"}, 32'(PENABLE), 32'h0);
        chk({name, "_pwr"}, 32'(PWRITE), 32'h0);
        chk({name, "_paddr"}, PADDR, 32'h0);
        chk({name, "_pwdata"}, PWDATA, 32'h0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // single pin
        intr_stat = 8'h08;
        tick();
        chk("t1_valid", 32'(irq_valid), 32'h1);
        chk("t1_id", 32'(irq_id), 32'd3);
        ack_now();
        chk("t1_req", 32'(bus_req), 32'h1);
        tick();
        chk("t1_setup_psel", 32'(PSEL), 32'h1);
        chk("t1_setup_pen", 32'(PENABLE), 32'h0);
        chk("t1_paddr", PADDR, 32'h4001_0018);
        chk("t1_pwdata", PWDATA, 32'h08);
        tick();
        chk("t1_access_pen", 32'(PENABLE), 32'h1);
        repeat (8) tick();
        chk("t1_stat", 32'(intr_stat), 32'h0);
        check_all_zero("t1_idle");

        // round robin with pin 1 re-firing once
        do_reset();
        refire = 8'h02;
        intr_stat = 8'h22;
        serve("t2_first", 1);
        serve("t2_second", 5);
        serve("t2_third", 1);
        repeat (10) tick();
        chk("t2_stat", 32'(intr_stat), 32'h0);

        // mask
        intr_stat = 8'h80;
        irq_mask = 8'h80;
        repeat (20) begin
            tick();
            chk("t3_masked", 32'(irq_valid), 32'h0);
        end
        irq_mask = 8'h00;
        tick();
        chk("t3_valid", 32'(irq_valid), 32'h1);
        chk("t3_id", 32'(irq_id), 32'd7);
        irq_mask = 8'h80;
        intr_stat = 8'h81;
        repeat (3) begin
            tick();
            chk("t3_hold_valid", 32'(irq_valid), 32'h1);
            chk("t3_hold_id", 32'(irq_id), 32'd7);
        end
        ack_now();
        serve("t3_next", 0);
        irq_mask = 8'h00;
        repeat (10) tick();

        // bus stall
        bus_gnt = 1'b0;
        intr_stat = 8'h10;
        serve("t4_id", 4);
        chk("t4_req0", 32'(bus_req), 32'h1);
        chk("t4_psel0", 32'(PSEL), 32'h0);
        repeat (4) begin
            tick();
            chk("t4_req", 32'(bus_req), 32'h1);
            chk("t4_psel", 32'(PSEL), 32'h0);
        end
        bus_gnt = 1'b1;
        tick();
        chk("t4_setup", 32'(PSEL), 32'h1);
        chk("t4_setup_pen", 32'(PENABLE), 32'h0);
        repeat (10) tick();

        // reset during ACCESS
        intr_stat = 8'h01;
        serve("t5_id", 0);
        wait_penable();
        rst = 1'b1;
        clr_cnt = 0;
        tick();
        check_all_zero("t5_rst");
        rst = 1'b0;
        tick();
        chk("t5_valid", 32'(irq_valid), 32'h1);
        chk("t5_id2", 32'(irq_id), 32'd0);
        ack_now();
        repeat (10) tick();

        // stuck status times out after exactly CLR_WAIT cycles
        stuck = 8'h04;
        intr_stat = 8'h04;
        serve("t6_id", 2);
        wait_penable();
        begin
            int n = 0;
            while (!irq_valid && n < 20) begin
                tick();
                n++;
            end
            chk("t6_latency", 32'(n), 32'd6);
        end
        chk("t6_reid", 32'(irq_id), 32'd2);
        stuck = 8'h00;
        ack_now();
        repeat (12) tick();
        chk("t6_stat", 32'(intr_stat), 32'h0);
        check_all_zero("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gpio_intr_ctrl.md
# gpio_intr_ctrl

Interrupt controller for the GPIO block. It watches the per-pin interrupt status vector and picks one pending, unmasked pin using round-robin arbitration. It presents that pin to the core with a valid/ack handshake. After the core acknowledges, it acts as an APB master: it requests the shared peripheral bus, then writes the matching bit of the GPIO interrupt-clear register.

## Interface

**Parameters**
- `NUM_PINS`, default 8 — number of GPIO pins/interrupt lines (1–32).
- `GPIO_BASE`, default 32'h0 — APB base address of the GPIO block.
- `CLR_OFFSET`, default 32'h18 — byte offset of the GPIO interrupt-clear register.
- `CLR_WAIT`, default 4 — maximum cycles to wait for a status bit to clear after the write.

**Ports**
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — reset, synchronous and active-high.
- `intr_stat` in NUM_PINS — GPIO interrupt status (sticky, cleared via the clear register).
- `irq_mask` in NUM_PINS — 1 = pin excluded from arbitration.
- `irq_valid` out 1 — a claimed interrupt is presented.
- `irq_id` out 5 — index of the presented pin.
- `irq_ack` in 1 — core finished servicing `irq_id`; sampled only while `irq_valid`.
- `bus_req` out 1 — request for the shared APB.
- `bus_gnt` in 1 — APB granted; the bus arbiter holds it high until `bus_req` falls.
- `PSEL`, `PENABLE`, `PWRITE` out 1 each — APB master controls.
- `PADDR` out 32, `PWDATA` out 32 — APB address and write data.

## Operation

- `pending = intr_stat & ~irq_mask`.
- Round-robin pointer `last` (log2 width, reset value NUM_PINS-1): the winner is the first set bit of `pending` searching `last+1, last+2, …` with wrap modulo NUM_PINS.
- **IDLE:** all outputs 0. If `pending != 0`, latch the winner into `irq_id` and go to PRESENT. Otherwise stay.
- **PRESENT:** `irq_valid=1`; `irq_id` is held stable.
  - Changes to `intr_stat` or `irq_mask` are ignored; the claim stands.
  - On `irq_ack`, go to REQ.
- **REQ:** `bus_req=1`. The state lasts at least one cycle. If `bus_gnt` is sampled high, go to SETUP.
- **SETUP:** `bus_req=1`, `PSEL=1`, `PENABLE=0`, `PWRITE=1`, `PADDR=GPIO_BASE+CLR_OFFSET`, `PWDATA=32'b1<<irq_id`. Go to ACCESS.
- **ACCESS:** same as SETUP but with `PENABLE=1`. No PREADY; the transfer completes this cycle. Go to WAIT_CLR.
- **WAIT_CLR:** APB outputs and `bus_req` are 0.
  - A counter starts at 0.
  - Exit to IDLE when `intr_stat[irq_id]==0` or the counter reaches CLR_WAIT-1. On exit, `last <= irq_id`.
  - A re-fired edge keeps the bit set; exit is then by timeout. The pin is re-arbitrated later, behind the other pins.
- Exactly one pin is cleared per transaction, and one interrupt is outstanding at a time.
- `irq_id` bits above log2(NUM_PINS) are 0.
- `bus_gnt` is ignored outside REQ.

## Timing

- **Reset values:**
  - `irq_valid`, `irq_id`, `bus_req`, `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA` are all 0.
  - State is IDLE, `last`=NUM_PINS-1, counter 0.
- **Reset mid-operation** (any state, including ACCESS): the next cycle has reset values. The APB transfer is abandoned and the claim is dropped. A still-set status bit is re-arbitrated, with pin 0 first.
- **Cycle latencies:**
  - `pending` nonzero in cycle N → `irq_valid` high in N+1.
  - `irq_ack` in cycle A → `bus_req` high in A+1.
  - `bus_gnt` sampled in cycle G (G ≥ A+1) → SETUP in G+1, ACCESS in G+2, `bus_req` low in G+3.
- The GPIO status falls about 2 cycles after ACCESS, so the earliest return to IDLE is about G+5. Best-case back-to-back service is about 7 cycles per interrupt plus core latency.
- **Simultaneous events:**
  - Multiple pins pending in IDLE → single winner per the round-robin rule.
  - `irq_ack` in the same cycle `irq_valid` rises is legal and counted.
  - `irq_ack` outside PRESENT is ignored.

## Test plan

1. **Single pin:** after reset, `intr_stat`=0x08 → `irq_valid`=1 next cycle with `irq_id`=3. Pulse `irq_ack`, tie `bus_gnt`=1 → SETUP/ACCESS with `PADDR`=GPIO_BASE+0x18 and `PWDATA`=0x08. Model clears the bit → IDLE with all outputs 0.
2. **Round-robin:** `intr_stat`=0x22 held; the model clears only the acked bit and re-sets bit 1 immediately after its clear → service order 1, 5, 1, with no pin served twice while the other is pending.
3. **Mask:** `intr_stat`=0x80, `irq_mask`=0x80 → `irq_valid` stays 0 for 20 cycles. Set `irq_mask`=0 → `irq_id`=7 one cycle later. Mask again during PRESENT → claim held.
4. **Bus stall:** `bus_gnt` held low 5 cycles after ack → `bus_req` held high for 5 cycles with `PSEL`=0. Grant → SETUP on the following cycle.
5. **Reset in ACCESS:** assert `rst` while `PENABLE`=1 → next cycle all outputs 0. Status 0x01 still set → `irq_id`=0 presented one cycle after `rst` drops.
6. **Stuck status:** the model never clears bit 2 → exit WAIT_CLR after exactly CLR_WAIT cycles. `irq_id`=2 is re-presented (sole pending pin).
